// File: rtl/soc1_cpu_debug_cmd_decoder.sv
// soc1_cpu_debug_cmd_decoder
// System-clock-side command decoder for the CPU debug slave. It synchronizes
// the JTAG update strobes, captures IR/DR contents on their rising edges and
// holds each data update as one buffered command behind a valid/ack handshake.
// An update that arrives while a command is still pending is dropped and
// flagged on the sticky overrun output.
module soc1_cpu_debug_cmd_decoder #(
    parameter int IR_W        = 2,
    parameter int DATA_W      = 38,
    parameter int ACT_BIT     = 34,
    parameter int SYNC_STAGES = 2,
    localparam int NCH        = 2 ** IR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [IR_W-1:0]   ir_in,
    input  logic [DATA_W-1:0] sr,
    input  logic              vs_uir,
    input  logic              vs_udr,
    input  logic              cmd_ack,
    input  logic              clr_overrun,
    output logic [DATA_W-1:0] jdo,
    output logic              cmd_valid,
    output logic [IR_W-1:0]   cmd_ir,
    output logic [NCH-1:0]    take_action,
    output logic [NCH-1:0]    take_no_action,
    output logic              overrun,
    output logic              busy
);

    logic [SYNC_STAGES-1:0] uir_sync;
    logic [SYNC_STAGES-1:0] udr_sync;
    logic                   uir_lvl;
    logic                   udr_lvl;
    logic                   uir_d;
    logic                   udr_d;
    logic                   uir_evt;
    logic                   udr_evt;
    logic [IR_W-1:0]        ir_q;
    logic                   act_q;
    logic                   slot_free;

    assign uir_lvl   = uir_sync[SYNC_STAGES-1];
    assign udr_lvl   = udr_sync[SYNC_STAGES-1];
    assign slot_free = !cmd_valid || cmd_ack;
    assign busy      = cmd_valid;

    // Strobe synchronizer chains; new samples enter at bit 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            uir_sync <= '0;
            udr_sync <= '0;
        end else begin
            uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
            udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
        end
    end

    // Edge registers; the event is registered so it lasts exactly one cycle
    // per rising edge of the synchronized level, however long the level stays high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            uir_d   <= 1'b0;
            udr_d   <= 1'b0;
            uir_evt <= 1'b0;
            udr_evt <= 1'b0;
        end else begin
            uir_d   <= uir_lvl;
            udr_d   <= udr_lvl;
            uir_evt <= uir_lvl & ~uir_d;
            udr_evt <= udr_lvl & ~udr_d;
        end
    end

    // IR capture; a coincident data update still sees the previous ir_q.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_q <= '0;
        end else if (uir_evt) begin
            ir_q <= ir_in;
        end
    end

    // Command slot: load on a free slot, drop and flag overrun when occupied.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jdo       <= '0;
            cmd_ir    <= '0;
            act_q     <= 1'b0;
            cmd_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (udr_evt && slot_free) begin
                jdo       <= sr;
                cmd_ir    <= ir_q;
                act_q     <= sr[ACT_BIT];
                cmd_valid <= 1'b1;
            end else if (cmd_ack) begin
                cmd_valid <= 1'b0;
            end

            // Set takes priority over a same-cycle clear.
            if (udr_evt && !slot_free) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

    // One-hot request decode from the registered command.
    always_comb begin
        take_action    = '0;
        take_no_action = '0;
        if (cmd_valid) begin
            if (act_q) begin
                take_action[cmd_ir] = 1'b1;
            end else begin
                take_no_action[cmd_ir] = 1'b1;
            end
        end
    end

endmodule
